// File: rtl/bs_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks: mode encodings,
// default geometry and a counter-width helper.
package bs_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    localparam int DEF_DW   = 1;
    localparam int DEF_NDIG = 16;

    // A one-digit word still needs a one-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/dsadd_digit.sv
// Combinational single-digit adder/subtractor: subtraction adds the inverted B
// digit, with the word's initial +1 supplied through cin.
module dsadd_digit
    import bs_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  mode_e         mode,
    input  logic          cin,
    output logic [DW-1:0] s,
    output logic          c,
    output logic          c_msb_in
);

    logic [DW-1:0] b_eff;

    assign b_eff = (mode == MODE_SUB) ? ~b : b;
    assign {c, s} = {1'b0, a} + {1'b0, b_eff} + {{DW{1'b0}}, cin};

    // The carry into the top bit falls out of that bit's sum without a second adder.
    assign c_msb_in = s[DW-1] ^ a[DW-1] ^ b_eff[DW-1];

endmodule

// File: rtl/dsaddsub.sv
// Digit-serial two's-complement adder/subtractor: words arrive LSB digit first,
// framed by isync, and the word-level carry/borrow and overflow are reported at the end.
module dsaddsub
    import bs_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int NDIG = DEF_NDIG
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          sub,
    input  logic          isync,
    output logic [DW-1:0] q,
    output logic          osync,
    output logic          cout,
    output logic          ovf,
    output logic          ovalid,
    output logic          ferr
);

    localparam int            CW    = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST  = CW'(NDIG - 1);
    localparam logic [CW-1:0] FIRST = (NDIG == 1) ? '0 : CW'(1);

    mode_e         mode;
    logic          carry;
    logic [CW-1:0] count;
    logic          active;

    mode_e         mode_eff;
    logic          cin;
    logic [DW-1:0] s;
    logic          c;
    logic          c_msb_in;
    logic          final_digit;

    // The isync digit takes its mode and carry-in straight from the inputs so a
    // new word needs no bubble after the previous one.
    assign mode_eff    = isync ? mode_e'(sub) : mode;
    assign cin         = isync ? sub : carry;
    assign final_digit = isync ? (NDIG == 1) : (active && (count == LAST));

    dsadd_digit #(
        .DW(DW)
    ) u_digit (
        .a        (a),
        .b        (b),
        .mode     (mode_eff),
        .cin      (cin),
        .s        (s),
        .c        (c),
        .c_msb_in (c_msb_in)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= '0;
            osync  <= 1'b0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            ovalid <= 1'b0;
            ferr   <= 1'b0;
            carry  <= 1'b0;
            mode   <= MODE_ADD;
            count  <= '0;
            active <= 1'b0;
        end else begin
            q      <= s;
            carry  <= c;
            osync  <= isync;
            ovalid <= final_digit;
            // An isync while a word is still open aborts it; that word never reports.
            ferr   <= isync && active;
            if (isync) begin
                mode <= mode_e'(sub);
            end
            if (final_digit) begin
                cout   <= c ^ (mode_eff == MODE_SUB);
                ovf    <= c_msb_in ^ c;
                active <= 1'b0;
                count  <= '0;
            end else if (isync) begin
                count  <= FIRST;
                active <= 1'b1;
            end else if (active) begin
                count  <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dsaddsub.sv
// Bench for dsaddsub: three geometries (4x4, 1x16, 16x1) against a plain
// 16-bit arithmetic model, with directed framing/reset cases on the 4x4 instance.
module tb_dsaddsub;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic [15:0] a_s [3];
    logic [15:0] b_s [3];
    logic        sub_s [3];
    logic        isync_s [3];
    logic [15:0] q_w [3];
    logic        osync_w [3];
    logic        cout_w [3];
    logic        ovf_w [3];
    logic        ovalid_w [3];
    logic        ferr_w [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int GDW = (g == 0) ? 4 : (g == 1) ? 1 : 16;
        localparam int GND = (g == 0) ? 4 : (g == 1) ? 16 : 1;
        logic [GDW-1:0] q_g;

        dsaddsub #(
            .DW   (GDW),
            .NDIG (GND)
        ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .a      (a_s[g][GDW-1:0]),
            .b      (b_s[g][GDW-1:0]),
            .sub    (sub_s[g]),
            .isync  (isync_s[g]),
            .q      (q_g),
            .osync  (osync_w[g]),
            .cout   (cout_w[g]),
            .ovf    (ovf_w[g]),
            .ovalid (ovalid_w[g]),
            .ferr   (ferr_w[g])
        );

        assign q_w[g] = 16'(q_g);
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_res [3][16];
    logic        exp_c   [3][16];
    logic        exp_v   [3][16];
    int          wr_p [3];
    int          rd_p [3];
    int          acc [3];
    int          idx [3];
    int          cnt_ov [3];
    int          cnt_fe [3];

    function automatic int dwOf(input int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : 16;
    endfunction

    function automatic int ndOf(input int g);
        return (g == 0) ? 4 : (g == 1) ? 16 : 1;
    endfunction

    function automatic int maskOf(input int g);
        return (1 << dwOf(g)) - 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Word-level reference: plain integer add/subtract, borrow as A<B, overflow from signed range.
    task automatic refModel(input int ua, input int ub, input logic sub,
                            output logic [15:0] r, output logic c, output logic v);
        int sa, sb, ur, sr;
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        ur = sub ? ua - ub : ua + ub;
        sr = sub ? sa - sb : sa + sb;
        r  = 16'(ur & 65535);
        c  = sub ? (ua < ub) : (ur > 65535);
        v  = (sr > 32767) || (sr < -32768);
    endtask

    task automatic driveDigits(input int g, input int ua, input int ub, input logic sub, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            isync_s[g] = (k == 0);
            sub_s[g]   = (k == 0) ? sub : 1'($urandom_range(0, 1));
            a_s[g]     = 16'((ua >> (k * dwOf(g))) & maskOf(g));
            b_s[g]     = 16'((ub >> (k * dwOf(g))) & maskOf(g));
        end
    endtask

    task automatic applyStimulus(input int g, input int ua, input int ub, input logic sub,
                                 input logic [15:0] r, input logic c, input logic v);
        exp_res[g][wr_p[g] % 16] = r;
        exp_c[g][wr_p[g] % 16]   = c;
        exp_v[g][wr_p[g] % 16]   = v;
        wr_p[g]++;
        driveDigits(g, ua, ub, sub, ndOf(g));
    endtask

    task automatic applyRandom(input int g);
        int ua, ub;
        logic sub, c, v;
        logic [15:0] r;
        ua  = int'($urandom_range(0, 65535));
        ub  = int'($urandom_range(0, 65535));
        sub = 1'($urandom_range(0, 1));
        refModel(ua, ub, sub, r, c, v);
        applyStimulus(g, ua, ub, sub, r, c, v);
    endtask

    task automatic idle(input int g, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            isync_s[g] = 1'b0;
            sub_s[g]   = 1'($urandom_range(0, 1));
            a_s[g]     = 16'($urandom_range(0, 65535));
            b_s[g]     = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic drain(input int g);
        for (int k = 0; k < 100 && rd_p[g] != wr_p[g]; k++) begin
            idle(g, 1);
        end
        checkOutput($sformatf("drain%0d", g), wr_p[g] - rd_p[g], 0);
    endtask

    // Reassembles q digits from osync onward and scores the word when ovalid arrives.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (reset) begin
                idx[g]  = ndOf(g);
                rd_p[g] = wr_p[g];
            end else begin
                if (osync_w[g]) begin
                    acc[g] = 0;
                    idx[g] = 0;
                end
                if (idx[g] < ndOf(g)) begin
                    acc[g] = acc[g] | ((int'(q_w[g]) & maskOf(g)) << (idx[g] * dwOf(g)));
                    idx[g]++;
                end
                if (ferr_w[g]) begin
                    cnt_fe[g]++;
                    checkOutput($sformatf("ferr_align%0d", g), osync_w[g], 1);
                end
                if (ovalid_w[g]) begin
                    cnt_ov[g]++;
                    checkOutput($sformatf("ovalid_pos%0d", g), idx[g], ndOf(g));
                    if (rd_p[g] == wr_p[g]) begin
                        checkOutput($sformatf("ovalid_spurious%0d", g), 1, 0);
                    end else begin
                        checkOutput($sformatf("result%0d", g), acc[g] & 65535, exp_res[g][rd_p[g] % 16]);
                        checkOutput($sformatf("cout%0d", g), cout_w[g], exp_c[g][rd_p[g] % 16]);
                        checkOutput($sformatf("ovf%0d", g), ovf_w[g], exp_v[g][rd_p[g] % 16]);
                        rd_p[g]++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            a_s[g] = '0; b_s[g] = '0; sub_s[g] = 1'b0; isync_s[g] = 1'b0;
            wr_p[g] = 0; rd_p[g] = 0; acc[g] = 0; idx[g] = ndOf(g);
            cnt_ov[g] = 0; cnt_fe[g] = 0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("reset_state%0d", g),
                        {q_w[g], osync_w[g], cout_w[g], ovf_w[g], ovalid_w[g], ferr_w[g]}, 0);
        end
        reset = 1'b0;

        $display("[TB] directed words on DW=4 NDIG=4");
        applyStimulus(0, 'h1234, 'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        idle(0, 2);
        applyStimulus(0, 'h0005, 'h0007, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        idle(0, 1);
        applyStimulus(0, 'h7FFF, 'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus(0, 'hFFFF, 'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain(0);
        checkOutput("b2b_ferr", cnt_fe[0], 0);
        idle(0, 3);
        checkOutput("cout_hold", cout_w[0], 1);

        $display("[TB] framing restart");
        base = cnt_ov[0];
        driveDigits(0, 'h5555, 'h1111, 1'b1, 2);
        applyStimulus(0, 'hF000, 'h2000, 1'b0, 16'h1000, 1'b1, 1'b0);
        drain(0);
        checkOutput("frame_ferr", cnt_fe[0], 1);
        checkOutput("frame_ovalid", cnt_ov[0] - base, 1);

        $display("[TB] reset mid-word");
        driveDigits(0, 'h1234, 'h0FCD, 1'b0, 2);
        @(negedge clk);
        reset = 1'b1;
        isync_s[0] = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid", {q_w[0], osync_w[0], cout_w[0], ovf_w[0], ovalid_w[0], ferr_w[0]}, 0);
        reset = 1'b0;
        base = cnt_ov[0];
        idle(0, 8);
        checkOutput("reset_no_ovalid", cnt_ov[0] - base, 0);
        applyStimulus(0, 'h1234, 'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        drain(0);
        checkOutput("reset_recover", cnt_ov[0] - base, 1);

        $display("[TB] random words on all geometries");
        for (int g = 0; g < 3; g++) begin
            int n;
            n = (g == 0) ? 200 : 1000;
            base = cnt_ov[g];
            for (int w = 0; w < n; w++) begin
                applyRandom(g);
                idle(g, int'($urandom_range(0, 2)));
            end
            drain(g);
            checkOutput($sformatf("ovalid_count%0d", g), cnt_ov[g] - base, n);
        end
        checkOutput("random_ferr", cnt_fe[1] + cnt_fe[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsaddsub.md
DSADDSUB -- requirements
Module: dsaddsub

Interface
REQ-001 Parameter DW, default 1, SHALL be the digit width in bits processed per cycle (DW >= 1).
REQ-002 Parameter NDIG, default 16, SHALL be the number of digits per word (NDIG >= 1); word width = DW*NDIG.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a  input  DW  operand A digit, LSB digit first.
REQ-006 b  input  DW  operand B digit, LSB digit first.
REQ-007 sub  input  1  mode: 0 = A+B, 1 = A-B; sampled only on the isync cycle.
REQ-008 isync  input  1  marks the LSB digit of a new word.
REQ-009 q  output  DW  result digit, registered.
REQ-010 osync  output  1  isync delayed one cycle, aligned with q.
REQ-011 cout  output  1  carry out (add) or borrow out (sub) of the word, held until the next word completes.
REQ-012 ovf  output  1  two's-complement overflow of the word, held until the next word completes.
REQ-013 ovalid  output  1  one-cycle pulse aligned with the q of the final (MSB) digit; cout/ovf are updated on the same cycle.
REQ-014 ferr  output  1  one-cycle pulse aligned with osync when isync arrives before the previous word's final digit.

Function
REQ-015 Per cycle, the block SHALL compute {c, s} = a + (mode ? ~b : b) + cin, where cin = sub on an isync cycle, else the carry register.
REQ-016 The mode register SHALL load sub on isync; non-isync digits SHALL use the mode register.
REQ-017 q <= s and carry <= c every non-reset cycle; latency a/b -> q is exactly 1 cycle.
REQ-018 A digit counter SHALL load 1 on isync (0 if NDIG==1) and set active; each later active digit increments it.
REQ-019 The final digit is an isync cycle when NDIG==1, or an active cycle with counter == NDIG-1.
REQ-020 On the final digit: cout <= c XOR mode; ovf <= (carry into bit DW-1) XOR c; ovalid pulses next cycle; active clears.
REQ-021 Digits arriving while not active and without isync SHALL still produce q via the carry chain, with no ovalid and no counter change.
REQ-022 isync while active and before the final digit SHALL restart the word (counter, mode, cin = sub) and pulse ferr; the aborted word produces no ovalid.
REQ-023 isync on the cycle immediately after a final digit SHALL be accepted as a back-to-back word with no ferr.

Reset
REQ-024 Under reset, q, osync, cout, ovf, ovalid, ferr, carry, mode, counter and active SHALL all be 0.
REQ-025 Reset mid-word SHALL discard the word; the first accepted input after reset is the next isync.

Structure
REQ-026 Mode encodings (ADD=0, SUB=1) and default DW/NDIG SHALL reside in the shared package bs_pkg.
REQ-027 The combinational digit adder (a, b, mode, cin -> s, c, c_msb_in) SHALL be a sub-module named dsadd_digit; the counter, mode and flag registers stay in dsaddsub.

Verification (DW=4, NDIG=4)
REQ-028 Add: 0x1234 + 0x0FCD, sub=0 -> q digits 1,0,2,2 (0x2201); ovalid on 4th q; cout=0, ovf=0.
REQ-029 Sub: 0x0005 - 0x0007, sub=1 -> q = 0xFFFE; cout=1 (borrow), ovf=0.
REQ-030 Overflow: 0x7FFF + 0x0001 -> q = 0x8000, ovf=1, cout=0; then 0xFFFF + 0x0001 -> q = 0x0000, cout=1, ovf=0, issued back-to-back with no ferr.
REQ-031 Framing: isync, 2 digits, isync again -> ferr pulse with the second osync; the first word gives no ovalid; the restarted word completes correctly.
REQ-032 Reset asserted after digit 2 of 0x1234 + 0x0FCD -> all outputs 0 next cycle; no ovalid until a new isync word completes.
REQ-033 Parameter sweep: DW=1, NDIG=16 and DW=16, NDIG=1 each match a 16-bit reference model for 1000 random add/sub words.
